// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Brief    : Shared FSM encoding and sizing helpers for multiplier_param.
// Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

  localparam int c_DEFAULT_WIDTH = 256;
  localparam int c_DEFAULT_LIMB  = 16;
  localparam int c_MAX_LIMB      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic int nlimb_of(input int width, input int limb);
    return width / limb;
  endfunction

  // The counter must be able to hold NLIMB itself, not just NLIMB-1.
  function automatic int cnt_width(input int nlimb);
    return $clog2(nlimb + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_row.sv
`default_nettype none
// ============================================================================
// Module   : mult_row
// Brief    : Combinational unsigned WIDTH x LIMB partial-product row.
// Revision : 1.0 - initial release
// ============================================================================
module mult_row #(
  parameter int WIDTH = 256,
  parameter int LIMB  = 16
) (
  input  logic [WIDTH-1:0]      i_a,
  input  logic [LIMB-1:0]       i_b,
  output logic [WIDTH+LIMB-1:0] o_p
);

  localparam int c_ROW_W = WIDTH + LIMB;

  assign o_p = c_ROW_W'(i_a) * c_ROW_W'(i_b);

endmodule
`default_nettype wire

// File: rtl/multiplier_param.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_param
// Brief    : Limb-serial unsigned multiplier / multiply-accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module multiplier_param
  import mult_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH,
  parameter int LIMB  = c_DEFAULT_LIMB
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic [2*WIDTH-1:0] out,
  output logic               done,
  output logic               busy
);

  localparam int c_NLIMB = nlimb_of(WIDTH, LIMB);
  localparam int c_CNT_W = cnt_width(c_NLIMB);
  localparam int c_ROW_W = WIDTH + LIMB;
  localparam int c_OUT_W = 2 * WIDTH;
  localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(c_NLIMB - 1);

  generate
    if ((WIDTH <= 0) || (LIMB <= 0) || (LIMB > c_MAX_LIMB) || ((WIDTH % LIMB) != 0)) begin : g_bad_params
      $fatal(1, "multiplier_param: WIDTH must be a positive multiple of LIMB, and LIMB <= 32");
    end
  endgenerate

  state_t               r_state;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_ROW_W-1:0]   r_row;
  logic [c_CNT_W-1:0]   r_row_idx;
  logic [c_OUT_W-1:0]   r_acc;
  logic [c_OUT_W-1:0]   r_out;
  logic                 r_done;
  logic                 r_busy;

  logic [c_ROW_W-1:0]   w_row;
  logic [c_OUT_W-1:0]   w_row_ext;
  logic [31:0]          w_shamt;
  logic [c_OUT_W-1:0]   w_acc_sum;

  // r_b shifts right one limb per MUL cycle, so the live limb is always the bottom one.
  mult_row #(
    .WIDTH (WIDTH),
    .LIMB  (LIMB)
  ) u_mult_row (
    .i_a (r_a),
    .i_b (r_b[LIMB-1:0]),
    .o_p (w_row)
  );

  assign w_row_ext = c_OUT_W'(r_row);
  assign w_shamt   = 32'(r_row_idx) * 32'(LIMB);
  assign w_acc_sum = r_acc + (w_row_ext << w_shamt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_row     <= '0;
      r_row_idx <= '0;
      r_acc     <= '0;
      r_out     <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= in1;
            r_b     <= in2;
            r_cnt   <= '0;
            r_acc   <= mode ? r_out : '0;
            r_busy  <= 1'b1;
            r_state <= MUL;
          end
        end
        MUL: begin
          r_row     <= w_row;
          r_row_idx <= r_cnt;
          r_cnt     <= r_cnt + c_CNT_W'(1);
          r_b       <= r_b >> LIMB;
          // The first MUL edge has no registered row yet, so nothing to add.
          if (r_cnt != '0) begin
            r_acc <= w_acc_sum;
          end
          if (r_cnt == c_LAST_CNT) begin
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          r_out   <= w_acc_sum;
          r_acc   <= w_acc_sum;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign out  = r_out;
  assign done = r_done;
  assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiplier_param
// Brief    : Directed and randomised checks of multiplier_param at three sizes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiplier_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // d_: defaults (256/16), s_: 64/32, u_: single limb 32/32
  logic         d_start, d_mode, d_done, d_busy;
  logic [255:0] d_in1, d_in2;
  logic [511:0] d_out;
  logic         s_start, s_mode, s_done, s_busy;
  logic [63:0]  s_in1, s_in2;
  logic [127:0] s_out;
  logic         u_start, u_mode, u_done, u_busy;
  logic [31:0]  u_in1, u_in2;
  logic [63:0]  u_out;

  int n_vec = 0;
  int n_err = 0;

  multiplier_param dut_d (
    .clk(clk), .reset(reset), .start(d_start), .mode(d_mode),
    .in1(d_in1), .in2(d_in2), .out(d_out), .done(d_done), .busy(d_busy)
  );

  multiplier_param #(.WIDTH(64), .LIMB(32)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .mode(s_mode),
    .in1(s_in1), .in2(s_in2), .out(s_out), .done(s_done), .busy(s_busy)
  );

  multiplier_param #(.WIDTH(32), .LIMB(32)) dut_u (
    .clk(clk), .reset(reset), .start(u_start), .mode(u_mode),
    .in1(u_in1), .in2(u_in2), .out(u_out), .done(u_done), .busy(u_busy)
  );

  task automatic drive(input int sel, input logic st, input logic [255:0] a,
                       input logic [255:0] b, input logic m);
    case (sel)
      0: begin d_start = st; d_in1 = a; d_in2 = b; d_mode = m; end
      1: begin s_start = st; s_in1 = a[63:0]; s_in2 = b[63:0]; s_mode = m; end
      default: begin u_start = st; u_in1 = a[31:0]; u_in2 = b[31:0]; u_mode = m; end
    endcase
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      0: return d_done;
      1: return s_done;
      default: return u_done;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0: return d_busy;
      1: return s_busy;
      default: return u_busy;
    endcase
  endfunction

  function automatic logic [511:0] get_out(input int sel);
    case (sel)
      0: return d_out;
      1: return 512'(s_out);
      default: return 512'(u_out);
    endcase
  endfunction

  // One operation; operands are scrambled after acceptance so they must not leak in.
  task automatic do_op(input int sel, input logic [255:0] a, input logic [255:0] b,
                       input logic m, output int lat, output logic [511:0] res);
    @(posedge clk); #1;
    drive(sel, 1'b1, a, b, m);
    @(posedge clk); #1;
    drive(sel, 1'b0, ~a, ~b, ~m);
    n_vec++;
    if (get_busy(sel) !== 1'b1) begin
      n_err++;
      $display("FAIL busy_after_start[%0d]: got %b want 1", sel, get_busy(sel));
    end
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (get_done(sel) === 1'b1) begin
        lat = c;
        break;
      end
    end
    res = get_out(sel);
    n_vec++;
    if (get_busy(sel) !== 1'b0) begin
      n_err++;
      $display("FAIL busy_at_done[%0d]: got %b want 0", sel, get_busy(sel));
    end
  endtask

  task automatic check_op(input string name, input int lat, input int exp_lat,
                          input logic [511:0] res, input logic [511:0] exp_res);
    n_vec++;
    if (lat !== exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_vec++;
    if (res !== exp_res) begin
      n_err++;
      $display("FAIL %s out: got %h want %h", name, res, exp_res);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(0, 1'b0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0);
    drive(2, 1'b0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      n_vec++;
      if (get_out(s) !== 512'd0) begin
        n_err++;
        $display("FAIL reset_out[%0d]: got %h want 0", s, get_out(s));
      end
      n_vec++;
      if (get_done(s) !== 1'b0 || get_busy(s) !== 1'b0) begin
        n_err++;
        $display("FAIL reset_flags[%0d]: got done=%b busy=%b want 0 0", s, get_done(s), get_busy(s));
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_max_product();
    logic [255:0] a;
    logic [511:0] res, exp_res;
    int lat;
    a = '1;
    exp_res = 512'd0 - (512'd1 << 257) + 512'd1;
    do_op(0, a, a, 1'b0, lat, res);
    check_op("max_product", lat, 17, res, exp_res);
  endtask

  task automatic test_small_mac();
    logic [511:0] res;
    int lat;
    do_op(0, 256'd3, 256'd5, 1'b0, lat, res);
    check_op("mul_3x5", lat, 17, res, 512'd15);
    do_op(0, 256'd2, 256'd7, 1'b1, lat, res);
    check_op("mac_2x7", lat, 17, res, 512'd29);
    do_op(0, 256'd0, 256'd123, 1'b0, lat, res);
    check_op("mul_zero", lat, 17, res, 512'd0);
  endtask

  task automatic test_ignored_start();
    int n_done, t_done;
    n_done = 0;
    t_done = -1;
    @(posedge clk); #1;
    drive(0, 1'b1, 256'd100, 256'd200, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 256'd7, 256'd9, 1'b1);
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (d_done === 1'b1) begin
        n_done++;
        t_done = c;
      end
      drive(0, (c == 2 || c == 9), 256'd7, 256'd9, 1'b1);
    end
    n_vec++;
    if (n_done !== 1 || t_done !== 17) begin
      n_err++;
      $display("FAIL ignored_start_done: got %0d pulses at %0d want 1 at 17", n_done, t_done);
    end
    n_vec++;
    if (d_out !== 512'd20000) begin
      n_err++;
      $display("FAIL ignored_start_out: got %h want %h", d_out, 512'd20000);
    end
  endtask

  task automatic test_reset_abort();
    logic [511:0] res;
    int lat, n_done;
    n_done = 0;
    @(posedge clk); #1;
    drive(0, 1'b1, 256'h1234, 256'h5678, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 256'h1234, 256'h5678, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_vec++;
    if (d_out !== 512'd0 || d_busy !== 1'b0 || d_done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_async: got out=%h busy=%b done=%b want 0 0 0", d_out, d_busy, d_done);
    end
    for (int c = 0; c < 23; c++) begin
      @(posedge clk); #1;
      if (c == 2) reset = 1'b1;
      if (d_done === 1'b1) n_done++;
    end
    n_vec++;
    if (n_done !== 0 || d_out !== 512'd0 || d_busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_after: got pulses=%0d out=%h busy=%b want 0 0 0", n_done, d_out, d_busy);
    end
    do_op(0, 256'hFFFF, 256'h10001, 1'b0, lat, res);
    check_op("post_abort", lat, 17, res, 512'hFFFF_FFFF);
  endtask

  task automatic test_wide64();
    logic [511:0] res;
    int lat;
    do_op(1, 256'hFFFF_FFFF_FFFF_FFFF, 256'd2, 1'b0, lat, res);
    check_op("w64_mul", lat, 3, res, 512'h1_FFFF_FFFF_FFFF_FFFE);
    do_op(1, 256'hFFFF_FFFF_FFFF_FFFF, 256'd2, 1'b1, lat, res);
    check_op("w64_mac", lat, 3, res, 512'h3_FFFF_FFFF_FFFF_FFFC);
    do_op(1, 256'hFFFF_FFFF_FFFF_FFFF, 256'hFFFF_FFFF_FFFF_FFFF, 1'b0, lat, res);
    check_op("w64_sq", lat, 3, res, 512'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    do_op(1, 256'hFFFF_FFFF_FFFF_FFFF, 256'hFFFF_FFFF_FFFF_FFFF, 1'b1, lat, res);
    check_op("w64_wrap", lat, 3, res, 512'hFFFF_FFFF_FFFF_FFFC_0000_0000_0000_0002);
  endtask

  task automatic test_single_limb();
    logic [511:0] res;
    int lat;
    do_op(2, 256'hFFFF_FFFF, 256'hFFFF_FFFF, 1'b0, lat, res);
    check_op("limb1_sq", lat, 2, res, 512'hFFFF_FFFE_0000_0001);
    do_op(2, 256'd2, 256'd3, 1'b1, lat, res);
    check_op("limb1_mac", lat, 2, res, 512'hFFFF_FFFE_0000_0007);
  endtask

  task automatic test_back_to_back();
    logic [511:0] res;
    int lat, n_done;
    int t_done[3];
    n_done = 0;
    t_done = '{-1, -1, -1};
    do_op(0, 256'd3, 256'd5, 1'b0, lat, res);
    check_op("b2b_seed", lat, 17, res, 512'd15);
    @(posedge clk); #1;
    drive(0, 1'b1, 256'd3, 256'd5, 1'b1);
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == 40) drive(0, 1'b0, 256'd3, 256'd5, 1'b1);
      if (d_done === 1'b1) begin
        if (n_done < 3) t_done[n_done] = c;
        n_done++;
        n_vec++;
        if (d_out !== 512'(15 * (n_done + 1))) begin
          n_err++;
          $display("FAIL b2b_out[%0d]: got %h want %0d", n_done, d_out, 15 * (n_done + 1));
        end
      end
    end
    n_vec++;
    if (n_done !== 3 || t_done[0] !== 18 || t_done[1] !== 36 || t_done[2] !== 54) begin
      n_err++;
      $display("FAIL b2b_spacing: got %0d pulses at %0d %0d %0d want 3 at 18 36 54",
               n_done, t_done[0], t_done[1], t_done[2]);
    end
  endtask

  task automatic test_random();
    logic [255:0] a, b;
    logic [511:0] res, model;
    logic m;
    int lat;
    model = 512'd60;
    for (int i = 0; i < 200; i++) begin
      for (int w = 0; w < 8; w++) begin
        a[w*32 +: 32] = $urandom;
        b[w*32 +: 32] = $urandom;
      end
      if (i % 16 == 0) a = '1;
      if (i % 16 == 8) b = '1;
      m = 1'($urandom_range(0, 1));
      do_op(0, a, b, m, lat, res);
      model = (m ? model : 512'd0) + 512'(a) * 512'(b);
      check_op($sformatf("random_%0d", i), lat, 17, res, model);
    end
  endtask

  initial begin
    test_reset();
    test_max_product();
    test_small_mac();
    test_ignored_start();
    test_reset_abort();
    test_wide64();
    test_single_limb();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
